// File: rtl/down_counter_pkg.sv
// Shared types and default sizing for the down-counter and its sibling up-counter benches.
package down_counter_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    localparam int unsigned DefWidth    = 4;
    localparam int unsigned DefMaxLoad  = 10;
    localparam int unsigned DefPrescale = 1;

endpackage

// File: rtl/down_counter_if.sv
// Control/status bundle of the down-counter; master drives it, the counter is the slave.
interface down_counter_if #(
    parameter int unsigned WIDTH = down_counter_pkg::DefWidth
) ();

    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             load_err;

    modport master (
        output enable,
        output load,
        output load_val,
        output auto_reload,
        input  count,
        input  busy,
        input  done,
        input  load_err
    );

    modport slave (
        input  enable,
        input  load,
        input  load_val,
        input  auto_reload,
        output count,
        output busy,
        output done,
        output load_err
    );

endinterface

// File: rtl/down_counter_tick_prescaler.sv
// Modulo-PRESCALE counter of enabled cycles; tick marks the last cycle of each period.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned   CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] Last = CntW'(PRESCALE - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // With PRESCALE=1 the counter is pinned at 0, so tick collapses to en.
    assign tick = en && (cnt_q == Last);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/down_counter.sv
// Loadable, bounded down-counter with terminal-count pulse and optional auto-reload.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned MAX_LOAD = DefMaxLoad,
    parameter int unsigned PRESCALE = DefPrescale
) (
    input logic           clk,
    input logic           reset_n,
    down_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MaxLoadW = WIDTH'(MAX_LOAD);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             load_err_q, load_err_d;
    logic [WIDTH-1:0] load_v;
    logic             over;
    logic             pre_en;
    logic             pre_clr;
    logic             tick;

    assign over    = bus.load_val > MaxLoadW;
    assign load_v  = over ? MaxLoadW : bus.load_val;
    assign pre_en  = (state_q == StRun) && bus.enable;
    // Holding the prescaler clear outside RUN covers the "cleared on entry to IDLE" case.
    assign pre_clr = bus.load || (state_q != StRun);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (pre_clr),
        .en      (pre_en),
        .tick    (tick)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            count_d    = load_v;
            reload_d   = load_v;
            load_err_d = over;
            if (load_v == '0) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end else begin
                state_d = StRun;
            end
        end else if (tick) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                done_d = 1'b1;
                if (bus.auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = StIdle;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            reload_q   <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.busy     = (state_q == StRun);
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_down_counter.sv
// Directed bench: PRESCALE=1 instance for most behaviour, PRESCALE=3 instance for gating.
module tb_down_counter;

    localparam int unsigned W   = 4;
    localparam int unsigned MAX = 10;

    logic clk = 1'b0;
    logic reset_n;

    int n_run  = 0;
    int n_fail = 0;

    down_counter_if #(.WIDTH(W)) u_if1 ();
    down_counter_if #(.WIDTH(W)) u_if3 ();

    down_counter #(
        .WIDTH    (W),
        .MAX_LOAD (MAX),
        .PRESCALE (1)
    ) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if1.slave)
    );

    down_counter #(
        .WIDTH    (W),
        .MAX_LOAD (MAX),
        .PRESCALE (3)
    ) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if3.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect1(input string tag, input int c, input bit b, input bit d, input bit e);
        check({tag, "_count"}, 32'(u_if1.count), 32'(c));
        check({tag, "_busy"}, 32'(u_if1.busy), 32'(b));
        check({tag, "_done"}, 32'(u_if1.done), 32'(d));
        check({tag, "_lerr"}, 32'(u_if1.load_err), 32'(e));
    endtask

    // Invariant monitor on the PRESCALE=1 instance, plus the bound on both.
    logic             ld_at_edge  = 1'b0;
    logic             rst_at_edge = 1'b0;
    logic             prev_busy   = 1'b1;
    logic             prev_done   = 1'b0;
    logic             prev_lerr   = 1'b0;
    logic [W-1:0]     prev_count  = '0;

    always @(posedge clk) begin
        ld_at_edge  <= u_if1.load;
        rst_at_edge <= reset_n;
    end

    always @(negedge clk) begin
        if (rst_at_edge) begin
            check("inv_max1", 32'(u_if1.count <= W'(MAX)), 32'd1);
            check("inv_max3", 32'(u_if3.count <= W'(MAX)), 32'd1);
            if (!prev_busy && !ld_at_edge) check("inv_idle_hold", 32'(u_if1.count), 32'(prev_count));
            if (prev_done && !ld_at_edge) check("inv_done_pulse", 32'(u_if1.done), 32'd0);
            if (prev_lerr && !ld_at_edge) check("inv_lerr_pulse", 32'(u_if1.load_err), 32'd0);
        end
        prev_busy  <= u_if1.busy;
        prev_done  <= u_if1.done;
        prev_lerr  <= u_if1.load_err;
        prev_count <= u_if1.count;
    end

    initial begin
        logic [7:0] en_pat;
        int         exp3 [8];

        // Reset holds everything at zero despite a pending load.
        reset_n = 1'b0;
        u_if1.enable = 1'b1; u_if1.load = 1'b1; u_if1.load_val = 4'd5; u_if1.auto_reload = 1'b0;
        u_if3.enable = 1'b1; u_if3.load = 1'b1; u_if3.load_val = 4'd5; u_if3.auto_reload = 1'b0;
        cyc(); cyc();
        expect1("rst_hold", 0, 0, 0, 0);
        check("rst_hold3_count", 32'(u_if3.count), 32'd0);
        reset_n = 1'b1; u_if1.load = 1'b0; u_if3.load = 1'b0;
        cyc();
        expect1("rst_rel", 0, 0, 0, 0);
        check("rst_rel3_busy", 32'(u_if3.busy), 32'd0);

        // Basic countdown of 3.
        u_if1.load = 1'b1; u_if1.load_val = 4'd3;
        cyc(); expect1("cd_load", 3, 1, 0, 0);
        u_if1.load = 1'b0;
        cyc(); expect1("cd_2", 2, 1, 0, 0);
        cyc(); expect1("cd_1", 1, 1, 0, 0);
        cyc(); expect1("cd_term", 0, 0, 1, 0);
        cyc(); expect1("cd_idle", 0, 0, 0, 0);

        // Clamp of 15 to 10, then run to zero.
        u_if1.load = 1'b1; u_if1.load_val = 4'd15;
        cyc(); expect1("clamp_load", 10, 1, 0, 1);
        u_if1.load = 1'b0;
        cyc(); expect1("clamp_9", 9, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc();
        expect1("clamp_1", 1, 1, 0, 0);
        cyc(); expect1("clamp_term", 0, 0, 1, 0);

        // Auto-reload 2,1,2,1 then drop auto_reload.
        u_if1.auto_reload = 1'b1; u_if1.load = 1'b1; u_if1.load_val = 4'd2;
        cyc(); expect1("ar_load", 2, 1, 0, 0);
        u_if1.load = 1'b0;
        cyc(); expect1("ar_1a", 1, 1, 0, 0);
        cyc(); expect1("ar_rel_a", 2, 1, 1, 0);
        cyc(); expect1("ar_1b", 1, 1, 0, 0);
        cyc(); expect1("ar_rel_b", 2, 1, 1, 0);
        u_if1.auto_reload = 1'b0;
        cyc(); expect1("ar_1c", 1, 1, 0, 0);
        cyc(); expect1("ar_stop", 0, 0, 1, 0);

        // Load of zero.
        u_if1.load = 1'b1; u_if1.load_val = 4'd0;
        cyc(); expect1("zero_load", 0, 0, 1, 0);
        u_if1.load = 1'b0;
        cyc(); expect1("zero_after", 0, 0, 0, 0);

        // Load of 7 colliding with a terminal tick.
        u_if1.load = 1'b1; u_if1.load_val = 4'd2;
        cyc(); expect1("col_load", 2, 1, 0, 0);
        u_if1.load = 1'b0;
        cyc(); expect1("col_1", 1, 1, 0, 0);
        u_if1.load = 1'b1; u_if1.load_val = 4'd7;
        cyc(); expect1("col_win", 7, 1, 0, 0);
        u_if1.load = 1'b0;
        cyc(); expect1("col_6", 6, 1, 0, 0);

        // Reset mid-run aborts silently; idle then ignores enable.
        reset_n = 1'b0;
        cyc(); expect1("abort", 0, 0, 0, 0);
        reset_n = 1'b1;
        cyc(); expect1("abort_idle", 0, 0, 0, 0);

        // PRESCALE=3 with enable gating.
        en_pat = 8'b1110_1101;  // bit i applies before edge i+1
        exp3   = '{2, 2, 2, 1, 1, 1, 1, 0};
        u_if3.enable = 1'b1; u_if3.load = 1'b1; u_if3.load_val = 4'd2;
        cyc();
        check("ps_load_count", 32'(u_if3.count), 32'd2);
        check("ps_load_busy", 32'(u_if3.busy), 32'd1);
        u_if3.load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            u_if3.enable = en_pat[i];
            cyc();
            check($sformatf("ps_count_%0d", i), 32'(u_if3.count), 32'(exp3[i]));
            check($sformatf("ps_done_%0d", i), 32'(u_if3.done), 32'(i == 7));
        end
        check("ps_busy_end", 32'(u_if3.busy), 32'd0);

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable, bounded down-counter with terminal-count handshake.
- It is the counting-down counterpart of the team's bounded up-counter.
- Shares its control style (clk, enable gating, bounded count) and is used as a programmable delay/timeout source.
- Bound MAX_LOAD matches the up-counter's count limit, so the same assertion style applies: count never exceeds the limit.

Parameters:
- WIDTH, 4: width of count and load_val.
- MAX_LOAD, 10: largest legal count value; must be less than 2**WIDTH.
- PRESCALE, 1: number of enabled cycles per decrement tick; must be 1 or more.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- enable  input  1  count-advance qualifier; when low, count and prescaler hold.
- load  input  1  one-cycle load strobe; legal in any state.
- load_val  input  WIDTH  start value, sampled only when load=1.
- auto_reload  input  1  1 = reload on terminal count and keep running; 0 = stop at 0. Sampled at the terminal tick.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on terminal count, or on a load of zero.
- load_err  output  1  one-cycle pulse when load_val > MAX_LOAD (value clamped).

Behaviour:
- Reset: reset_n is sampled low at posedge clk.
  - count=0, busy=0, done=0, load_err=0, reload register=0, prescaler=0, state=IDLE.
  - Reset overrides load and enable in the same cycle.
  - Reset mid-RUN aborts with no done pulse.
- States: IDLE and RUN. busy = (state==RUN), registered.
- Load (any state, highest priority after reset):
  - Clamped value v = min(load_val, MAX_LOAD).
  - count<=v, reload register<=v, prescaler<=0.
  - load_err<=1 for one cycle if load_val > MAX_LOAD.
  - If v==0: state<=IDLE, done<=1 for one cycle.
  - If v>0: state<=RUN.
  - A load coinciding with a terminal tick wins: no done pulse from the tick.
- Tick: tick = (state==RUN) and enable and (prescaler==PRESCALE-1).
  - The prescaler increments on each RUN&enable cycle and wraps to 0 on tick.
  - It holds when enable=0. It is cleared on load and on entry to IDLE.
- RUN, tick with count>1: count<=count-1.
- RUN, tick with count==1 (terminal): done<=1 for one cycle.
  - auto_reload=1: count<=reload register, remain RUN.
  - auto_reload=0: count<=0, state<=IDLE, busy<=0.
- IDLE: count holds, enable is ignored, and the counter never decrements below 0.
- Latency:
  - Load at edge N: count valid after edge N.
  - With PRESCALE=1 and enable held high, the load of L>0 at edge N gives done high during the cycle after edge N+L, and count==0 in that same cycle (auto_reload=0).
- Invariants, each covered by an assertion in the bench:
  - count <= MAX_LOAD always.
  - done and load_err are never high for two consecutive cycles unless driven by back-to-back events.
  - busy==0 implies count is stable.

Decomposition:
- Package down_counter_pkg:
  - state enum (IDLE, RUN).
  - Default constants for WIDTH, MAX_LOAD and PRESCALE, shared with the up-counter bench.
- One sub-module, tick_prescaler:
  - Inputs: clk, reset_n, clr, en.
  - Output: tick.
  - PRESCALE-cycle modulo counter.
  - Instantiated once; with PRESCALE=1 it degenerates to tick=en.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with load=1, load_val=5 → count=0, busy=0, done=0, load_err=0 after release.
2. Basic countdown: PRESCALE=1, enable=1, load_val=3, auto_reload=0 → count 3,2,1,0 on consecutive cycles, done pulse with count==0, busy falls the same cycle.
3. Clamp: load_val=4'd15 → load_err pulse for one cycle, count=10, busy=1; the count then reaches 0 after 10 enabled cycles, and count<=10 is never violated.
4. Enable gating and prescale: PRESCALE=3, load_val=2, enable toggled 1,0,1,1,… → count decrements only after every 3rd enabled cycle, and holds during enable=0.
5. Auto-reload: load_val=2, auto_reload=1 → count 2,1,2,1,… with a done pulse at each reload and busy held high. Dropping auto_reload → stops at 0.
6. Collisions: load_val=0 → done pulse with busy=0. A load of 7 on the same cycle as a terminal tick → count=7, no done. reset_n low mid-RUN → IDLE, count=0, no done.
